// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, opcodes,
// ALU codes and datapath mux selects.
package multicycle_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10,
      S_TRAP     = 4'd11
   } state_e;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] ALUOP_ADD  = 2'b00;
   localparam logic [1:0] ALUOP_SUB  = 2'b01;
   localparam logic [1:0] ALUOP_FUNC = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_MEM    = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   function automatic logic [1:0] imm_src(input logic [6:0] op);
      case (op)
         OP_SW:   return IMM_S;
         OP_BEQ:  return IMM_B;
         OP_JAL:  return IMM_J;
         default: return IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_dec.sv
// Combinational ALU decoder: maps aluOp/f3/f7[5] to an ALU operation and flags
// function codes the datapath does not implement.
module alu_dec
   import multicycle_ctrl_pkg::*;
(
   input  logic [1:0] aluOp,
   input  logic       op5,
   input  logic [2:0] f3,
   input  logic       f7b5,
   output logic [2:0] aluControl,
   output logic       valid
);

   always_comb begin
      aluControl = ALU_ADD;
      valid      = 1'b1;
      case (aluOp)
         ALUOP_ADD: aluControl = ALU_ADD;
         ALUOP_SUB: aluControl = ALU_SUB;
         ALUOP_FUNC: begin
            case (f3)
               // Only R-type (op[5]=1) can encode sub; addi ignores f7.
               3'b000:  aluControl = (op5 && f7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  aluControl = ALU_SLT;
               3'b110:  aluControl = ALU_OR;
               3'b111:  aluControl = ALU_AND;
               default: valid = 1'b0;
            endcase
         end
         default: valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences PC/IR/memory/register-file enables and
// mux selects, counts retired instructions and traps on illegal encodings.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       op,
   input  logic [2:0]       f3,
   input  logic [6:0]       f7,
   input  logic             zero,
   output logic             pcWrite,
   output logic             adrSrc,
   output logic             irWrite,
   output logic             memWrite,
   output logic             regWrite,
   output logic [1:0]       resultSrc,
   output logic [1:0]       aluSrcA,
   output logic [1:0]       aluSrcB,
   output logic [1:0]       immSrc,
   output logic [2:0]       aluControl,
   output logic             instrDone,
   output logic             trap,
   output logic [CNT_W-1:0] retired
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e           state_q;
   logic             trap_q;
   logic [CNT_W-1:0] retired_q;

   logic       pc_update, branch, adr_src, ir_write, mem_write, reg_write, done;
   logic [1:0] res_src, src_a, src_b, alu_op, alu_op_dec;
   logic [2:0] dec_ctrl;
   logic       dec_valid;
   logic       unused_f7;

   assign unused_f7 = ^{f7[6], f7[4:0]};

   // DECODE asks the decoder about the function field so illegal f3 traps early.
   assign alu_op_dec = (state_q == S_DECODE) ? ALUOP_FUNC : alu_op;

   alu_dec u_alu_dec (
      .aluOp      (alu_op_dec),
      .op5        (op[5]),
      .f3         (f3),
      .f7b5       (f7[5]),
      .aluControl (dec_ctrl),
      .valid      (dec_valid)
   );

   always_comb begin
      pc_update = 1'b0;
      branch    = 1'b0;
      adr_src   = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      done      = 1'b0;
      res_src   = RES_ALUOUT;
      src_a     = SRCA_PC;
      src_b     = SRCB_RS2;
      alu_op    = ALUOP_ADD;
      case (state_q)
         S_FETCH: begin
            ir_write  = 1'b1;
            pc_update = 1'b1;
            src_b     = SRCB_FOUR;
            res_src   = RES_ALURES;
         end
         S_DECODE: begin
            src_a = SRCA_OLDPC;
            src_b = SRCB_IMM;
         end
         S_MEMADR: begin
            src_a = SRCA_RS1;
            src_b = SRCB_IMM;
         end
         S_MEMREAD: adr_src = 1'b1;
         S_MEMWB: begin
            res_src   = RES_MEM;
            reg_write = 1'b1;
            done      = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src   = 1'b1;
            mem_write = 1'b1;
            done      = 1'b1;
         end
         S_EXECR: begin
            src_a  = SRCA_RS1;
            alu_op = ALUOP_FUNC;
         end
         S_EXECI: begin
            src_a  = SRCA_RS1;
            src_b  = SRCB_IMM;
            alu_op = ALUOP_FUNC;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            done      = 1'b1;
         end
         S_JAL: begin
            src_a     = SRCA_OLDPC;
            src_b     = SRCB_FOUR;
            pc_update = 1'b1;
         end
         S_BEQ: begin
            src_a  = SRCA_RS1;
            alu_op = ALUOP_SUB;
            branch = 1'b1;
            done   = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         trap_q    <= 1'b0;
         retired_q <= '0;
      end else begin
         if (done)
            retired_q <= retired_q + CNT_ONE;
         case (state_q)
            S_FETCH: state_q <= S_DECODE;
            S_DECODE: begin
               case (op)
                  OP_LW, OP_SW: state_q <= S_MEMADR;
                  OP_R:         state_q <= dec_valid ? S_EXECR : S_TRAP;
                  OP_I:         state_q <= dec_valid ? S_EXECI : S_TRAP;
                  OP_JAL:       state_q <= S_JAL;
                  OP_BEQ:       state_q <= (f3 == 3'b000) ? S_BEQ : S_TRAP;
                  default:      state_q <= S_TRAP;
               endcase
               trap_q <= !((op == OP_LW) || (op == OP_SW) || (op == OP_JAL) ||
                           ((op == OP_R || op == OP_I) && dec_valid) ||
                           (op == OP_BEQ && f3 == 3'b000));
            end
            S_MEMADR:   state_q <= (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_q <= S_MEMWB;
            S_MEMWB:    state_q <= S_FETCH;
            S_MEMWRITE: state_q <= S_FETCH;
            S_EXECR:    state_q <= S_ALUWB;
            S_EXECI:    state_q <= S_ALUWB;
            S_ALUWB:    state_q <= S_FETCH;
            S_JAL:      state_q <= S_ALUWB;
            S_BEQ:      state_q <= S_FETCH;
            default:    state_q <= S_TRAP;
         endcase
      end
   end

   // Enables are gated by reset so an in-flight instruction cannot commit.
   assign pcWrite    = ~reset & (pc_update | (branch & zero));
   assign irWrite    = ~reset & ir_write;
   assign memWrite   = ~reset & mem_write;
   assign regWrite   = ~reset & reg_write;
   assign instrDone  = ~reset & done;
   assign adrSrc     = adr_src;
   assign resultSrc  = res_src;
   assign aluSrcA    = src_a;
   assign aluSrcB    = src_b;
   assign immSrc     = imm_src(op);
   assign aluControl = (state_q == S_DECODE) ? ALU_ADD : dec_ctrl;
   assign trap       = trap_q;
   assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: expected per-cycle control vectors are
// queued per instruction and compared against the DUT one cycle at a time.
module tb_multicycle_ctrl;

   localparam int CNT_W = 4;

   localparam logic [6:0] T_LW  = 7'b0000011;
   localparam logic [6:0] T_SW  = 7'b0100011;
   localparam logic [6:0] T_R   = 7'b0110011;
   localparam logic [6:0] T_I   = 7'b0010011;
   localparam logic [6:0] T_JAL = 7'b1101111;
   localparam logic [6:0] T_BEQ = 7'b1100011;

   typedef struct packed {
      logic       pcw, adr, irw, mw, rw;
      logic [1:0] rs, sa, sb, imm;
      logic [2:0] alu;
      logic       done, trp;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic [6:0] op, f7;
   logic [2:0] f3;
   logic zero;
   logic pcWrite, adrSrc, irWrite, memWrite, regWrite, instrDone, trap;
   logic [1:0] resultSrc, aluSrcA, aluSrcB, immSrc;
   logic [2:0] aluControl;
   logic [CNT_W-1:0] retired;

   exp_t q[$];
   int checks = 0;
   int failures = 0;
   logic [CNT_W-1:0] exp_ret;

   always #5 clk = ~clk;

   multicycle_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .op(op), .f3(f3), .f7(f7), .zero(zero),
      .pcWrite(pcWrite), .adrSrc(adrSrc), .irWrite(irWrite), .memWrite(memWrite),
      .regWrite(regWrite), .resultSrc(resultSrc), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
      .immSrc(immSrc), .aluControl(aluControl), .instrDone(instrDone), .trap(trap),
      .retired(retired)
   );

   function automatic exp_t mk(input logic pcw, adr, irw, mw, rw,
                               input logic [1:0] rs, sa, sb, imm,
                               input logic [2:0] alu, input logic done, trp);
      return exp_t'({pcw, adr, irw, mw, rw, rs, sa, sb, imm, alu, done, trp});
   endfunction

   function automatic exp_t observe();
      return exp_t'({pcWrite, adrSrc, irWrite, memWrite, regWrite, resultSrc, aluSrcA,
                     aluSrcB, immSrc, aluControl, instrDone, trap});
   endfunction

   function automatic logic [1:0] exp_imm(input logic [6:0] o);
      if (o == T_SW) return 2'b01;
      if (o == T_BEQ) return 2'b10;
      if (o == T_JAL) return 2'b11;
      return 2'b00;
   endfunction

   task automatic push_instr(input logic [6:0] o, input logic [2:0] f,
                             input logic [6:0] s7, input logic z);
      logic [1:0] im;
      logic [2:0] ac;
      logic legal;
      im = exp_imm(o);
      ac = 3'b000;
      legal = 1'b1;
      if (o == T_R || o == T_I) begin
         case (f)
            3'b000:  ac = (o == T_R && s7[5]) ? 3'b001 : 3'b000;
            3'b010:  ac = 3'b101;
            3'b110:  ac = 3'b011;
            3'b111:  ac = 3'b010;
            default: legal = 1'b0;
         endcase
      end else if (o == T_BEQ) begin
         legal = (f == 3'b000);
      end else if (o != T_LW && o != T_SW && o != T_JAL) begin
         legal = 1'b0;
      end
      q.push_back(mk(1, 0, 1, 0, 0, 2'b10, 2'b00, 2'b10, im, 3'b000, 0, 0));
      q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, im, 3'b000, 0, 0));
      if (!legal) begin
         for (int i = 0; i < 12; i++)
            q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, im, 3'b000, 0, 1));
      end else if (o == T_LW) begin
         q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, im, 3'b000, 0, 0));
         q.push_back(mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, im, 3'b000, 0, 0));
         q.push_back(mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, im, 3'b000, 1, 0));
      end else if (o == T_SW) begin
         q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, im, 3'b000, 0, 0));
         q.push_back(mk(0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, im, 3'b000, 1, 0));
      end else if (o == T_R || o == T_I) begin
         q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, (o == T_R) ? 2'b00 : 2'b01, im, ac, 0, 0));
         q.push_back(mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, im, 3'b000, 1, 0));
      end else if (o == T_JAL) begin
         q.push_back(mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, im, 3'b000, 0, 0));
         q.push_back(mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, im, 3'b000, 1, 0));
      end else begin
         q.push_back(mk(z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, im, 3'b001, 1, 0));
      end
   endtask

   // Pops n expected vectors (all when n<0), one per clock, sampled at negedge.
   task automatic drain(input int n, input string name);
      int k;
      exp_t e, o;
      k = (n < 0) ? q.size() : n;
      for (int i = 0; i < k; i++) begin
         @(negedge clk);
         e = q.pop_front();
         o = observe();
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL %s cycle%0d: got %h want %h", name, i + 1, o, e);
         end
         if (e.done) exp_ret = exp_ret + 1'b1;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_retired(input string name);
      checks++;
      if (retired !== exp_ret) begin
         failures++;
         $display("FAIL %s retired: got %0d want %0d", name, retired, exp_ret);
      end
   endtask

   task automatic run(input logic [6:0] o, input logic [2:0] f, input logic [6:0] s7,
                      input logic z, input string name);
      op = o; f3 = f; f7 = s7; zero = z;
      push_instr(o, f, s7, z);
      drain(-1, name);
      check_retired(name);
   endtask

   task automatic check_reset_enables(input string name);
      @(negedge clk);
      checks++;
      if ({pcWrite, irWrite, memWrite, regWrite, instrDone} !== 5'b0) begin
         failures++;
         $display("FAIL %s enables: got %b want 00000", name,
                  {pcWrite, irWrite, memWrite, regWrite, instrDone});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; op = T_R; f3 = 3'b000; f7 = 7'b0100000; zero = 1'b1;
      @(posedge clk); #1;
      check_reset_enables("reset_init");
      exp_ret = '0;
      check_retired("reset_init");
      reset = 1'b0;
      run(T_R, 3'b000, 7'b0000000, 1'b0, "first_add");
      // Interrupt an R-type in EXECR with a 3-cycle reset.
      push_instr(T_R, 3'b000, 7'b0100000, 1'b1);
      drain(2, "pre_reset");
      q.delete();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) check_reset_enables("reset_mid_execr");
      exp_ret = '0;
      check_retired("reset_mid_execr");
      reset = 1'b0;
      run(T_R, 3'b000, 7'b0100000, 1'b0, "after_reset_sub");
   endtask

   task automatic test_lw_sw();
      run(T_LW, 3'b010, 7'b0000000, 1'b1, "lw");
      run(T_SW, 3'b010, 7'b0000000, 1'b1, "sw");
   endtask

   task automatic test_rtype();
      run(T_R, 3'b000, 7'b0100000, 1'b0, "r_sub");
      run(T_R, 3'b111, 7'b0000000, 1'b0, "r_and");
      run(T_R, 3'b110, 7'b0000000, 1'b0, "r_or");
      run(T_R, 3'b010, 7'b0000000, 1'b0, "r_slt");
   endtask

   task automatic test_itype();
      run(T_I, 3'b000, 7'b0100000, 1'b0, "addi_f7set");
      run(T_I, 3'b111, 7'b0000000, 1'b0, "andi");
      run(T_I, 3'b110, 7'b0000000, 1'b0, "ori");
      run(T_I, 3'b010, 7'b0000000, 1'b0, "slti");
   endtask

   task automatic test_beq_jal();
      run(T_BEQ, 3'b000, 7'b0000000, 1'b1, "beq_taken");
      run(T_BEQ, 3'b000, 7'b0000000, 1'b0, "beq_not_taken");
      run(T_JAL, 3'b000, 7'b0000000, 1'b0, "jal");
   endtask

   task automatic test_back_to_back();
      // Enough retirements to wrap the 4-bit counter.
      for (int i = 0; i < 18; i++)
         run(T_BEQ, 3'b000, 7'b0000000, i[0], "b2b_beq_wrap");
      run(T_LW, 3'b010, 7'b0000000, 1'b0, "b2b_lw");
      run(T_JAL, 3'b000, 7'b0000000, 1'b1, "b2b_jal");
   endtask

   task automatic clear_trap(input string name);
      reset = 1'b1;
      check_reset_enables(name);
      reset = 1'b0;
      checks++;
      if (trap !== 1'b0) begin
         failures++;
         $display("FAIL %s trap_clear: got %b want 0", name, trap);
      end
      exp_ret = '0;
      check_retired(name);
   endtask

   task automatic test_illegal();
      run(7'b1111111, 3'b000, 7'b0000000, 1'b1, "illegal_op");
      clear_trap("illegal_op_reset");
      run(T_SW, 3'b010, 7'b0000000, 1'b0, "sw_after_trap");
      run(T_R, 3'b001, 7'b0000000, 1'b1, "illegal_r_f3");
      clear_trap("illegal_r_reset");
      run(T_BEQ, 3'b001, 7'b0000000, 1'b1, "illegal_beq_f3");
      clear_trap("illegal_beq_reset");
      run(T_I, 3'b000, 7'b0000000, 1'b0, "addi_after_trap");
   endtask

   initial begin
      exp_ret = '0;
      test_reset();
      test_lw_sw();
      test_rtype();
      test_itype();
      test_beq_jal();
      test_back_to_back();
      test_illegal();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
